// File: rtl/mem_write_checker.sv
// Self-checking monitor for data-memory write traffic: compares bus writes against a
// programmable FIFO of expected (address, data) pairs and reports sticky pass/fail.
module mem_write_checker #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 8,
    parameter int unsigned       CNT_W    = 16,
    parameter int unsigned       TIMEOUT  = 1000,
    parameter logic [ADDR_W-1:0] IGN_BASE = 32'h60,
    parameter logic [ADDR_W-1:0] IGN_MASK = 32'hFFFFFFFC,
    parameter bit                STRICT   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [ADDR_W-1:0] exp_adr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    input  logic              clear,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_adr,
    output logic [DATA_W-1:0] err_data,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  cyc_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] fifo_adr  [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       count;

    logic full, hit, ignored, last_cycle;
    logic push, pop, begin_run, set_mismatch, set_timeout, set_noexp;

    assign full       = (count == CNT_FULL);
    assign hit        = (count != '0) && (DataAdr == fifo_adr[rd_ptr]) &&
                        (WriteData == fifo_data[rd_ptr]);
    assign ignored    = ((DataAdr & IGN_MASK) == IGN_BASE);
    assign last_cycle = (TIMEOUT != 0) && (cyc_cnt == LAST_CYC);

    assign exp_ready = (state == IDLE) && !full;
    assign busy      = (state == RUN);
    assign pass      = (state == PASS);
    assign fail      = (state == FAIL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        push         = 1'b0;
        pop          = 1'b0;
        begin_run    = 1'b0;
        set_mismatch = 1'b0;
        set_timeout  = 1'b0;
        set_noexp    = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    push = exp_valid && !full;
                    if (start) begin
                        begin_run = 1'b1;
                        // a push in the start cycle counts towards the expectation set
                        if (count == '0 && !push) begin
                            state_nxt = FAIL;
                            set_noexp = 1'b1;
                        end else begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (MemWrite) begin
                        if (hit) begin
                            pop = 1'b1;
                            if (count == CNT_ONE) state_nxt = PASS;
                        end else if (!ignored && STRICT) begin
                            state_nxt    = FAIL;
                            set_mismatch = 1'b1;
                        end
                    end
                    // a final match or a mismatch on the timeout edge takes precedence
                    if (last_cycle && state_nxt == RUN) begin
                        state_nxt   = FAIL;
                        set_timeout = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_adr[wr_ptr]  <= exp_adr;
            fifo_data[wr_ptr] <= exp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            cyc_cnt   <= '0;
            match_cnt <= '0;
            err_code  <= '0;
            err_adr   <= '0;
            err_data  <= '0;
        end else if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            cyc_cnt   <= '0;
            match_cnt <= '0;
            err_code  <= '0;
            err_adr   <= '0;
            err_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                count  <= count + CNT_ONE;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                count     <= count - CNT_ONE;
                match_cnt <= match_cnt + CNT_W'(1);
            end
            if (begin_run) begin
                cyc_cnt   <= '0;
                match_cnt <= '0;
            end
            if (state == RUN && cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (set_noexp) err_code <= 2'd3;
            if (set_timeout) err_code <= 2'd2;
            if (set_mismatch) begin
                err_code <= 2'd1;
                err_adr  <= DataAdr;
                err_data <= WriteData;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: three configurations share one stimulus stream and are
// compared every cycle against a queue-based reference model.
module tb_mem_write_checker;

    localparam int N = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3;

    logic        clk = 1'b0;
    logic        reset, exp_valid, start, clear, MemWrite;
    logic [31:0] exp_adr, exp_data, DataAdr, WriteData;

    logic        exp_ready [N];
    logic        busy      [N];
    logic        pass      [N];
    logic        fail      [N];
    logic [1:0]  err_code  [N];
    logic [31:0] err_adr   [N];
    logic [31:0] err_data  [N];
    logic [15:0] match_cnt [N];
    logic [15:0] cyc_cnt   [N];

    int depth_c [N] = '{8, 8, 4};
    bit strict_c[N] = '{1'b1, 1'b0, 1'b1};
    int to_c    [N] = '{1000, 1000, 10};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_write_checker u_strict (
        .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_ready(exp_ready[0]),
        .exp_adr(exp_adr), .exp_data(exp_data), .start(start), .clear(clear),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .busy(busy[0]), .pass(pass[0]), .fail(fail[0]), .err_code(err_code[0]),
        .err_adr(err_adr[0]), .err_data(err_data[0]), .match_cnt(match_cnt[0]),
        .cyc_cnt(cyc_cnt[0])
    );

    mem_write_checker #(.STRICT(1'b0)) u_lenient (
        .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_ready(exp_ready[1]),
        .exp_adr(exp_adr), .exp_data(exp_data), .start(start), .clear(clear),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .busy(busy[1]), .pass(pass[1]), .fail(fail[1]), .err_code(err_code[1]),
        .err_adr(err_adr[1]), .err_data(err_data[1]), .match_cnt(match_cnt[1]),
        .cyc_cnt(cyc_cnt[1])
    );

    mem_write_checker #(.DEPTH(4), .TIMEOUT(10)) u_short (
        .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_ready(exp_ready[2]),
        .exp_adr(exp_adr), .exp_data(exp_data), .start(start), .clear(clear),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .busy(busy[2]), .pass(pass[2]), .fail(fail[2]), .err_code(err_code[2]),
        .err_adr(err_adr[2]), .err_data(err_data[2]), .match_cnt(match_cnt[2]),
        .cyc_cnt(cyc_cnt[2])
    );

    // reference model: an expectation queue per configuration plus outcome bookkeeping
    int          m_st   [N];
    int          m_cyc  [N];
    int          m_mcnt [N];
    int          m_code [N];
    logic [31:0] m_eadr [N];
    logic [31:0] m_edata[N];
    logic [63:0] mq     [N][$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = S_IDLE; m_cyc[i] = 0; m_mcnt[i] = 0; m_code[i] = 0;
            m_eadr[i] = '0; m_edata[i] = '0;
            mq[i].delete();
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < N; i++) begin
            if (clear) begin
                m_st[i] = S_IDLE; m_cyc[i] = 0; m_mcnt[i] = 0; m_code[i] = 0;
                m_eadr[i] = '0; m_edata[i] = '0;
                mq[i].delete();
            end else if (m_st[i] == S_IDLE) begin
                if (exp_valid && mq[i].size() < depth_c[i]) mq[i].push_back({exp_adr, exp_data});
                if (start) begin
                    m_cyc[i] = 0; m_mcnt[i] = 0;
                    if (mq[i].size() == 0) begin
                        m_st[i] = S_FAIL; m_code[i] = 3;
                    end else begin
                        m_st[i] = S_RUN;
                    end
                end
            end else if (m_st[i] == S_RUN) begin
                int nxt = S_RUN;
                if (MemWrite) begin
                    if (mq[i].size() > 0 && mq[i][0] == {DataAdr, WriteData}) begin
                        void'(mq[i].pop_front());
                        m_mcnt[i]++;
                        if (mq[i].size() == 0) nxt = S_PASS;
                    end else if (DataAdr >= 32'h60 && DataAdr <= 32'h63) begin
                        nxt = S_RUN;
                    end else if (strict_c[i]) begin
                        nxt = S_FAIL; m_code[i] = 1;
                        m_eadr[i] = DataAdr; m_edata[i] = WriteData;
                    end
                end
                if (nxt == S_RUN && to_c[i] != 0 && m_cyc[i] == to_c[i] - 1) begin
                    nxt = S_FAIL; m_code[i] = 2;
                end
                if (m_cyc[i] < 65535) m_cyc[i]++;
                m_st[i] = nxt;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("i%0d.exp_ready", i), 64'(exp_ready[i]),
                64'(m_st[i] == S_IDLE && mq[i].size() < depth_c[i]));
            chk($sformatf("i%0d.busy", i), 64'(busy[i]), 64'(m_st[i] == S_RUN));
            chk($sformatf("i%0d.pass", i), 64'(pass[i]), 64'(m_st[i] == S_PASS));
            chk($sformatf("i%0d.fail", i), 64'(fail[i]), 64'(m_st[i] == S_FAIL));
            chk($sformatf("i%0d.err_code", i), 64'(err_code[i]), 64'(m_code[i]));
            chk($sformatf("i%0d.err_adr", i), 64'(err_adr[i]), 64'(m_eadr[i]));
            chk($sformatf("i%0d.err_data", i), 64'(err_data[i]), 64'(m_edata[i]));
            chk($sformatf("i%0d.match_cnt", i), 64'(match_cnt[i]), 64'(m_mcnt[i]));
            chk($sformatf("i%0d.cyc_cnt", i), 64'(cyc_cnt[i]), 64'(m_cyc[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
        check_all();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        exp_valid = 1'b1; exp_adr = a; exp_data = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    logic [31:0] pa[8], pd[8];
    int          n, r, k;

    initial begin
        reset = 1'b1; exp_valid = 1'b0; start = 1'b0; clear = 1'b0; MemWrite = 1'b0;
        exp_adr = '0; exp_data = '0; DataAdr = '0; WriteData = '0;
        #1; model_reset(); check_all();
        idle(2);
        reset = 1'b0;
        idle(1);

        // baseline program
        push(100, 7); do_start();
        bus(96, 3); bus(96, 5); idle(2); bus(100, 7); idle(2);

        // strict mismatch, then the expected write afterwards
        do_clear();
        push(100, 7); do_start();
        bus(104, 7); idle(1); bus(100, 7); idle(1);

        // out-of-order writes
        do_clear();
        push(32'h20, 1); push(32'h24, 2); do_start();
        bus(32'h24, 2); bus(32'h20, 1); bus(32'h24, 2); idle(2);

        // timeout with no writes, then a final match on the timeout edge
        do_clear();
        push(100, 7); do_start(); idle(12);
        do_clear();
        push(100, 7); do_start(); idle(9); bus(100, 7); idle(2);

        // FIFO limits
        do_clear();
        exp_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_adr = 32'h200 + 4 * i; exp_data = i; tick();
        end
        exp_valid = 1'b0;
        do_clear();
        do_start(); idle(1);
        do_clear();
        exp_valid = 1'b1; exp_adr = 32'h300; exp_data = 32'hAB; start = 1'b1;
        tick();
        exp_valid = 1'b0; start = 1'b0;
        idle(1); bus(32'h300, 32'hAB); idle(1);

        // asynchronous reset between edges in RUN
        do_clear();
        push(32'h10, 1); push(32'h14, 2); push(32'h18, 3); do_start();
        bus(32'h10, 1);
        #2 reset = 1'b1;
        #1 model_reset(); check_all();
        tick();
        reset = 1'b0;
        idle(1);

        // clear and start together in RUN, then prove the FIFO was flushed
        push(32'h10, 1); push(32'h14, 2); push(32'h18, 3); do_start();
        bus(32'h10, 1);
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        do_start(); idle(1);

        // randomized programs
        for (int round = 0; round < 14; round++) begin
            do_clear();
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                pa[j] = 32'h40 + 4 * $urandom_range(0, 15);
                pd[j] = $urandom_range(0, 7);
                push(pa[j], pd[j]);
            end
            do_start();
            for (int c = 0; c < 25; c++) begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    k = $urandom_range(0, n - 1);
                    bus(pa[k], pd[k]);
                end else if (r < 7) begin
                    bus(32'h60 + $urandom_range(0, 3), $urandom);
                end else if (r == 7) begin
                    bus(32'h40 + 4 * $urandom_range(0, 15), $urandom_range(0, 7));
                end else begin
                    tick();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-checking monitor for processor data-memory write traffic.
- Generalises the single-write "7 to address 0x64" end-of-program check:
  - holds a programmable FIFO of expected (address, data) writes;
  - ignores writes to a configurable address window;
  - optional strict/lenient handling of unexpected writes;
  - cycle-count timeout.
- Sits beside top (or an FPGA build) on the MemWrite/DataAdr/WriteData bus; reports sticky pass/fail with diagnostics.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- DEPTH, 8, expectation FIFO entries (power of 2, >=2).
- CNT_W, 16, width of cycle and match counters.
- TIMEOUT, 1000, RUN cycles before timeout failure; 0 disables timeout.
- IGN_BASE, 32'h60, base of ignored address window.
- IGN_MASK, 32'hFFFFFFFC, a write is ignored when (DataAdr & IGN_MASK) == IGN_BASE.
- STRICT, 1, 1 = unexpected non-ignored write fails; 0 = such writes are skipped.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- exp_valid  in  1  push request for an expectation entry.
- exp_ready  out  1  high when a push will be accepted.
- exp_adr  in  ADDR_W  expected write address.
- exp_data  in  DATA_W  expected write data.
- start  in  1  begin checking.
- clear  in  1  synchronous return to IDLE with FIFO flush.
- MemWrite  in  1  monitored write strobe.
- DataAdr  in  ADDR_W  monitored address.
- WriteData  in  DATA_W  monitored data.
- busy  out  1  state == RUN.
- pass  out  1  sticky success.
- fail  out  1  sticky failure.
- err_code  out  2  failure cause: 0 none, 1 mismatch, 2 timeout, 3 no expectations.
- err_adr  out  ADDR_W  DataAdr of the failing write (0 unless err_code == 1).
- err_data  out  DATA_W  WriteData of the failing write (0 unless err_code == 1).
- match_cnt  out  CNT_W  expectations matched so far.
- cyc_cnt  out  CNT_W  cycles spent in RUN; saturates at all-ones.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; FIFO empty;
  - all outputs 0 except exp_ready = 1.
- States: IDLE, RUN, PASS, FAIL; pass = (state == PASS), fail = (state == FAIL).
- IDLE:
  - exp_ready = !full.
  - Push occurs on a rising edge with exp_valid && exp_ready. Push while full is refused with no side effects.
  - start: if the FIFO count after any same-cycle push is 0, next state is FAIL with err_code 3; otherwise next state is RUN. cyc_cnt and match_cnt are cleared.
  - An entry pushed in the same cycle as start is included in the check.
- RUN:
  - exp_ready = 0.
  - cyc_cnt increments every cycle.
  - Each edge with MemWrite = 1 is evaluated in this priority order:
    1. DataAdr == head address and WriteData == head data: pop the head and increment match_cnt. If that was the last entry, next state is PASS.
    2. Address is in the ignore window: no effect.
    3. STRICT = 1: next state is FAIL, err_code = 1, capture err_adr and err_data.
    4. STRICT = 0: no effect.
  - Timeout: when TIMEOUT != 0 and cyc_cnt == TIMEOUT-1 at an edge where PASS is not reached, next state is FAIL with err_code 2.
    - A final match on the timeout edge wins, giving PASS.
    - A mismatch on the timeout edge reports err_code 1.
  - One write is evaluated per cycle. A write held high for N cycles counts N times.
- PASS and FAIL:
  - Sticky; all monitored inputs, start and exp_valid are ignored.
  - Counters and err_* hold their values.
- clear:
  - Valid in any state. Next state is IDLE; FIFO flushed; counters and err_* zeroed.
  - clear has priority over start, push and bus evaluation in the same cycle.
- reset asserted mid-RUN: immediate return to the reset values, regardless of clk.
- FIFO: circular buffer with read/write pointers plus an explicit count (0..DEPTH), so full and empty are unambiguous at wrap-around.
- Bus fields are compared with exact equality. Behaviour with X values on the bus is undefined.

Test Plan:
- Baseline program: push (100,7); start; bus writes (96,3), (96,5), then (100,7) two cycles later -> pass = 1 one cycle after the (100,7) edge, match_cnt = 1, err_code = 0.
- Strict mismatch: push (100,7); start; bus write (104,7) -> fail = 1, err_code = 1, err_adr = 104, err_data = 7. A following (100,7) write leaves state FAIL.
- Lenient ordering: STRICT = 0, push (0x20,1), (0x24,2); bus writes (0x24,2), (0x20,1), (0x24,2) -> pass after the third write, match_cnt = 2.
- Timeout: TIMEOUT = 10, push (100,7), no bus writes -> fail with err_code = 2 exactly 10 cycles after RUN is entered, cyc_cnt = 10. A final match on cycle 10 instead -> pass.
- FIFO limits: push DEPTH+2 entries -> exp_ready low after DEPTH accepts. start with an empty FIFO -> err_code = 3. Push and start in the same cycle -> RUN with count 1.
- Reset/clear mid-RUN: with 3 entries loaded and 1 matched, assert reset asynchronously between edges -> all outputs zero immediately, exp_ready = 1. Repeat with clear and start in the same cycle -> IDLE, FIFO empty.
